// File: rtl/aes128_enc_round.sv
// Iterative AES-128 encryption datapath: one round per clock, S-box bank accessed externally.
// Optional protocol-error pulse on o_err is compiled in with AES128_ENC_ERR_EN.
module aes128_enc_round (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [1407:0] i_exkey,
  input  logic          i_key_ok,
  input  logic [127:0]  i_din,
  input  logic          i_din_en,
  output logic [127:0]  o_dout,
  output logic          o_dout_en,
  output logic          o_busy,
  output logic          o_sbox_use,
  output logic [127:0]  o_sbox_din,
  input  logic [127:0]  i_sbox_dout,
  output logic          o_err
);

  logic [127:0] r_state;
  logic [3:0]   r_round;
  logic [127:0] rk [16];
  logic [127:0] rk_cur;
  logic [127:0] sr_out;
  logic [127:0] mc_out;
  logic         busy;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n of the state sits at [127-8n], row n%4, column n/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return t;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      t[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return t;
  endfunction

  // Slots 11..15 are unreachable round values, padded so the lookup is total.
  for (genvar k = 0; k < 16; k++) begin : g_rk
    if (k < 11) begin : g_key
      assign rk[k] = i_exkey[1407-128*k -: 128];
    end else begin : g_pad
      assign rk[k] = '0;
    end
  end

  assign busy       = (r_round != 4'd0);
  assign o_busy     = busy;
  assign o_sbox_use = busy;
  assign o_sbox_din = r_state;

  always_comb begin
    rk_cur = rk[r_round];
    sr_out = shift_rows(i_sbox_dout);
    mc_out = mix_columns(sr_out);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= '0;
      r_round   <= '0;
      o_dout    <= '0;
      o_dout_en <= 1'b0;
    end else begin
      o_dout_en <= 1'b0;
      if (busy) begin
        // A key reload mid-block abandons the block; it also beats the final round.
        if (!i_key_ok) begin
          r_round <= '0;
        end else if (r_round == 4'd10) begin
          o_dout    <= sr_out ^ rk_cur;
          o_dout_en <= 1'b1;
          r_round   <= '0;
        end else begin
          r_state <= mc_out ^ rk_cur;
          r_round <= r_round + 4'd1;
        end
      end else if (i_din_en && i_key_ok) begin
        r_state <= i_din ^ rk[0];
        r_round <= 4'd1;
      end
    end
  end

`ifdef AES128_ENC_ERR_EN
  logic r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (i_din_en && (busy || !i_key_ok)) || (busy && !i_key_ok);
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes128_enc_round.sv
// Scoreboard bench for aes128_enc_round with a behavioural S-box bank and key expansion.
module tb_aes128_enc_round;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R1_C  = 128'h00102030405060708090a0b0c0d0e0f0;
`ifdef AES128_ENC_ERR_EN
  localparam int ERR_W = 1;
`else
  localparam int ERR_W = 0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [1407:0] i_exkey = '0;
  logic          i_key_ok = 1'b0;
  logic [127:0]  i_din = '0;
  logic          i_din_en = 1'b0;
  logic [127:0]  o_dout;
  logic          o_dout_en;
  logic          o_busy;
  logic          o_sbox_use;
  logic [127:0]  o_sbox_din;
  logic [127:0]  i_sbox_dout;
  logic          o_err;

  aes128_enc_round dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_exkey(i_exkey), .i_key_ok(i_key_ok),
    .i_din(i_din), .i_din_en(i_din_en), .o_dout(o_dout), .o_dout_en(o_dout_en),
    .o_busy(o_busy), .o_sbox_use(o_sbox_use), .o_sbox_din(o_sbox_din),
    .i_sbox_dout(i_sbox_dout), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [127:0] exp_q[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return t;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] ek;
    rcon = 8'h01;
    ek = '0;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) begin
        w[i] = key[127-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % 4 == 0) begin
          t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
          rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
        w[i] = w[i-4] ^ t;
      end
      ek[1407-32*i -: 32] = w[i];
    end
    return ek;
  endfunction

  assign i_sbox_dout = sub_bytes(o_sbox_din);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every result pulse pops one expected ciphertext.
  always @(negedge i_clk) begin
    if (o_err === 1'b1) err_cnt++;
    if (o_dout_en === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got %h with no block pending", o_dout);
      end else begin
        chk("ciphertext", o_dout, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; the accept edge is the next posedge.
  task automatic issue(input logic [127:0] pt, input bit push, input logic [127:0] exp);
    i_din = pt;
    i_din_en = 1'b1;
    if (push) exp_q.push_back(exp);
    @(negedge i_clk);
    i_din_en = 1'b0;
    accept_cyc = cyc;
  endtask

  logic [127:0] first_sbox;

  task automatic wait_done(input string tag, input int exp_busy);
    int busy_n;
    int sbox_n;
    bit seen;
    busy_n = 0;
    sbox_n = 0;
    seen = 1'b0;
    first_sbox = o_sbox_din;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (o_dout_en === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (o_busy === 1'b1) busy_n++;
        if (o_sbox_use === 1'b1) sbox_n++;
        @(negedge i_clk);
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no o_dout_en within 20 cycles, expected one", tag);
    end else begin
      chk({tag, "_latency"}, 128'(cyc - accept_cyc), 128'd10);
      chk({tag, "_busy_cycles"}, 128'(busy_n), 128'(exp_busy));
      chk({tag, "_sbox_cycles"}, 128'(sbox_n), 128'(exp_busy));
      chk({tag, "_busy_at_done"}, 128'(o_busy), 128'd0);
    end
  endtask

  initial begin
    int saved_done;

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_dout", o_dout, '0);
    chk("rst_dout_en", 128'(o_dout_en), '0);
    chk("rst_busy", 128'(o_busy), '0);
    chk("rst_sbox_use", 128'(o_sbox_use), '0);
    chk("rst_err", 128'(o_err), '0);
    i_rst = 1'b0;

    // App. B
    i_exkey = expand(KEY_B);
    i_key_ok = 1'b1;
    @(negedge i_clk);
    issue(PT_B, 1'b1, CT_B);
    chk("b_busy_after_accept", 128'(o_busy), 128'd1);
    wait_done("b", 10);

    // App. C.1 twice, second issued in the result cycle of the first
    i_exkey = expand(KEY_C);
    @(negedge i_clk);
    issue(PT_C, 1'b1, CT_C);
    wait_done("c1a", 10);
    chk("c1_round1_sbox_din", first_sbox, R1_C);
    issue(PT_C, 1'b1, CT_C);
    wait_done("c1b", 10);

    // Start strobe during round 5 is ignored
    i_exkey = expand(KEY_B);
    @(negedge i_clk);
    issue(PT_B, 1'b1, CT_B);
    repeat (4) @(negedge i_clk);
    i_din = PT_C;
    i_din_en = 1'b1;
    @(negedge i_clk);
    i_din_en = 1'b0;
    wait_done("ignore", 5);
    @(negedge i_clk);
    chk("ignore_err_count", 128'(err_cnt), 128'(ERR_W));

    // Start strobe with keys not ready
    saved_done = done_cnt;
    i_key_ok = 1'b0;
    i_din = PT_B;
    i_din_en = 1'b1;
    @(negedge i_clk);
    i_din_en = 1'b0;
    chk("nokey_busy", 128'(o_busy), '0);
    repeat (12) @(negedge i_clk);
    chk("nokey_no_result", 128'(done_cnt), 128'(saved_done));
    chk("nokey_dout_held", o_dout, CT_B);

    // Key dropped during round 7 aborts the block
    i_key_ok = 1'b1;
    issue(PT_C, 1'b0, '0);
    repeat (6) @(negedge i_clk);
    i_key_ok = 1'b0;
    @(negedge i_clk);
    chk("abort_busy", 128'(o_busy), '0);
    repeat (12) @(negedge i_clk);
    chk("abort_no_result", 128'(done_cnt), 128'(saved_done));
    chk("abort_dout_held", o_dout, CT_B);
    chk("abort_err_count", 128'(err_cnt), 128'(3 * ERR_W));

    // Reload and rerun App. B
    i_exkey = expand(KEY_B);
    i_key_ok = 1'b1;
    @(negedge i_clk);
    issue(PT_B, 1'b1, CT_B);
    wait_done("reload", 10);

    // Reset at round 4, then rerun C.1
    i_exkey = expand(KEY_C);
    @(negedge i_clk);
    issue(PT_C, 1'b0, '0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("midrst_dout", o_dout, '0);
    chk("midrst_busy", 128'(o_busy), '0);
    chk("midrst_sbox_use", 128'(o_sbox_use), '0);
    chk("midrst_sbox_din", o_sbox_din, '0);
    chk("midrst_err", 128'(o_err), '0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    issue(PT_C, 1'b1, CT_C);
    wait_done("postrst", 10);
    chk("postrst_round1_sbox_din", first_sbox, R1_C);

    repeat (3) @(negedge i_clk);
    chk("total_results", 128'(done_cnt), 128'd6);
    chk("queue_drained", 128'(exp_q.size()), '0);
    chk("total_err_count", 128'(err_cnt), 128'(3 * ERR_W));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
